// File: rtl/ret_addr_stack.sv
`default_nettype none
// ============================================================================
//  Module   : ret_addr_stack
//  Brief    : Hardware return-address stack for CALL/RET. Top entry is read
//             combinationally. Sticky overflow/underflow flags report misuse.
//             Optional macro RET_STACK_WRAP_EN turns a push on a full stack
//             into a circular push that discards the oldest entry. Without
//             it, a push on a full stack is dropped.
//  Revision : 1.0 - initial release
// ============================================================================
module ret_addr_stack #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         stack_in,
  output logic [WIDTH-1:0]         stack_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int                c_AW      = $clog2(DEPTH);
  localparam logic [c_AW-1:0]   c_IDX_ONE = {{(c_AW-1){1'b0}}, 1'b1};
  localparam logic [c_AW:0]     c_CNT_ONE = {{c_AW{1'b0}}, 1'b1};
  localparam logic [c_AW:0]     c_FULL    = (c_AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW:0]    r_count;
  logic             r_overflow;
  logic             r_underflow;

  // Physical slot of the oldest entry. It only moves when a circular push
  // discards the bottom of the stack; otherwise the stack is bottom-anchored.
  logic [c_AW-1:0]  w_base;
`ifdef RET_STACK_WRAP_EN
  logic [c_AW-1:0]  r_base;
  assign w_base = r_base;
`else
  assign w_base = '0;
`endif

  logic             w_empty;
  logic             w_full;
  logic [c_AW-1:0]  w_top_idx;
  logic [c_AW-1:0]  w_wr_idx;
  logic             w_we;
  logic [c_AW-1:0]  w_waddr;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == c_FULL);
  // Index arithmetic wraps modulo DEPTH, so count==0 and count==DEPTH both
  // map to in-range slots; the empty case is masked at the output.
  assign w_top_idx = w_base + r_count[c_AW-1:0] - c_IDX_ONE;
  assign w_wr_idx  = w_base + r_count[c_AW-1:0];

  // A push always writes unless it lands on a full stack in the non-wrap
  // build. Push+pop on a non-empty stack replaces the top in place; on a
  // full wrap-mode stack the next free slot coincides with the oldest entry.
`ifdef RET_STACK_WRAP_EN
  assign w_we    = reset && push;
`else
  assign w_we    = reset && push && (pop || !w_full);
`endif
  assign w_waddr = (pop && !w_empty) ? w_top_idx : w_wr_idx;

  assign stack_out = w_empty ? '0 : r_mem[w_top_idx];
  assign count     = r_count;
  assign empty     = w_empty;
  assign full      = w_full;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

  // Storage write port; contents are not reset because they are masked
  // until rewritten.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= stack_in;
    end
  end

  // Occupancy, base pointer and sticky error flags; reset has priority.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
`ifdef RET_STACK_WRAP_EN
      r_base      <= '0;
`endif
    end else if (push && pop) begin
      if (w_empty) begin
        r_count     <= r_count + c_CNT_ONE;
        r_underflow <= 1'b1;
      end
    end else if (push) begin
      if (!w_full) begin
        r_count <= r_count + c_CNT_ONE;
      end else begin
        r_overflow <= 1'b1;
`ifdef RET_STACK_WRAP_EN
        r_base     <= r_base + c_IDX_ONE;
`endif
      end
    end else if (pop) begin
      if (!w_empty) begin
        r_count <= r_count - c_CNT_ONE;
      end else begin
        r_underflow <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ret_addr_stack.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ret_addr_stack
//  Brief    : Self-checking bench for ret_addr_stack using a queue-based
//             behavioural model and a scoreboard of expected states and
//             expected read data. Honours RET_STACK_WRAP_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ret_addr_stack;

  localparam int WIDTH = 12;
  localparam int DEPTH = 8;

  logic             clk;
  logic             reset;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] stack_in;
  logic [WIDTH-1:0] stack_out;
  logic [3:0]       count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  ret_addr_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .stack_in  (stack_in),
    .stack_out (stack_out),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string            tag;
    int               cnt;
    logic [WIDTH-1:0] out;
    logic             emp;
    logic             ful;
    logic             ovf;
    logic             unf;
  } exp_t;

  exp_t             sb_state [$];
  logic [WIDTH-1:0] sb_read  [$];

  // Behavioural reference: back of the queue is the top of the stack.
  logic [WIDTH-1:0] m_stk [$];
  logic             m_ovf;
  logic             m_unf;

  int n_tests;
  int n_fail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_step(input logic rst_n, input logic p, input logic q,
                            input logic [WIDTH-1:0] d);
    if (!rst_n) begin
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (p && q) begin
      if (m_stk.size() == 0) begin
        m_stk.push_back(d);
        m_unf = 1'b1;
      end else begin
        m_stk[m_stk.size()-1] = d;
      end
    end else if (p) begin
      if (m_stk.size() < DEPTH) begin
        m_stk.push_back(d);
      end else begin
        m_ovf = 1'b1;
`ifdef RET_STACK_WRAP_EN
        void'(m_stk.pop_front());
        m_stk.push_back(d);
`endif
      end
    end else if (q) begin
      if (m_stk.size() > 0) void'(m_stk.pop_back());
      else m_unf = 1'b1;
    end
  endtask

  // One clock cycle: drive, check zero-latency pop data, then check the
  // state visible after the edge.
  task automatic cyc(input string tag, input logic rst_n, input logic p,
                     input logic q, input logic [WIDTH-1:0] d);
    exp_t e;
    @(negedge clk);
    reset    = rst_n;
    push     = p;
    pop      = q;
    stack_in = d;
    if (rst_n && q && !p && m_stk.size() > 0) begin
      sb_read.push_back(m_stk[m_stk.size()-1]);
      #1;
      chk({tag, ".rd"}, 32'(stack_out), 32'(sb_read.pop_front()));
    end
    model_step(rst_n, p, q, d);
    e.tag = tag;
    e.cnt = m_stk.size();
    e.out = (m_stk.size() > 0) ? m_stk[m_stk.size()-1] : '0;
    e.emp = (m_stk.size() == 0);
    e.ful = (m_stk.size() == DEPTH);
    e.ovf = m_ovf;
    e.unf = m_unf;
    sb_state.push_back(e);
    @(posedge clk);
    #1;
    if (sb_state.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty at compare", tag);
    end else begin
      e = sb_state.pop_front();
      chk({e.tag, ".cnt"}, 32'(count),     32'(e.cnt));
      chk({e.tag, ".out"}, 32'(stack_out), 32'(e.out));
      chk({e.tag, ".emp"}, 32'(empty),     32'(e.emp));
      chk({e.tag, ".ful"}, 32'(full),      32'(e.ful));
      chk({e.tag, ".ovf"}, 32'(overflow),  32'(e.ovf));
      chk({e.tag, ".unf"}, 32'(underflow), 32'(e.unf));
    end
  endtask

  task automatic do_rst(input string tag);
    cyc(tag, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic do_push(input string tag, input logic [WIDTH-1:0] d);
    cyc(tag, 1'b1, 1'b1, 1'b0, d);
  endtask

  task automatic do_pop(input string tag);
    cyc(tag, 1'b1, 1'b0, 1'b1, '0);
  endtask

  task automatic do_swap(input string tag, input logic [WIDTH-1:0] d);
    cyc(tag, 1'b1, 1'b1, 1'b1, d);
  endtask

  task automatic fill8;
    for (int i = 1; i <= DEPTH; i++) do_push("fill", WIDTH'(i));
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    reset    = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    stack_in = '0;
    m_ovf    = 1'b0;
    m_unf    = 1'b0;

    // Basic LIFO order with zero-latency reads
    do_rst("rst0");
    do_push("p010", 12'h010);
    do_push("p020", 12'h020);
    do_push("p030", 12'h030);
    cyc("idle", 1'b1, 1'b0, 1'b0, 12'hABC);
    for (int i = 0; i < 3; i++) do_pop("pop_a");

    // Underflow from empty, then push keeps the sticky flag
    do_pop("unf_pop");
    do_push("p0ab", 12'h0AB);

    // Push while full
    do_rst("rst1");
    fill8();
    do_push("pfull", 12'h0FF);
    for (int i = 0; i < DEPTH; i++) do_pop("pop_full");
    do_pop("pop_unf");

    // Replace top at count 2
    do_rst("rst2");
    do_push("p010b", 12'h010);
    do_push("p020b", 12'h020);
    do_swap("sw055", 12'h055);
    do_pop("pop_sw1");
    do_pop("pop_sw2");

    // Replace top while full: no overflow
    do_rst("rst3");
    fill8();
    do_swap("sw123", 12'h123);
    do_pop("pop_sw3");

    // Push+pop on empty acts as push and flags underflow
    do_rst("rst4");
    do_swap("sw_emp", 12'h077);

    // Reset with push while count=5 and overflow set
    do_rst("rst5");
    fill8();
    do_push("povf", 12'h0EE);
    for (int i = 0; i < 3; i++) do_pop("pop5");
    cyc("rst_push", 1'b0, 1'b1, 1'b0, 12'h3C3);
    do_push("post_rst", 12'h5A5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard timeout so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/ret_addr_stack.md
RET_ADDR_STACK -- requirements
Module: ret_addr_stack

Interface
REQ-001 SHALL have parameter WIDTH, default 12, the return-address width, matching the PC width.
REQ-002 SHALL have parameter DEPTH, default 8, the number of entries (power of two, at least 2).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, reset; synchronous and active-low.
REQ-005 SHALL have port push, input, 1, a CALL request that stores stack_in.
REQ-006 SHALL have port pop, input, 1, a RET request that removes the top entry.
REQ-007 SHALL have port stack_in, input, WIDTH, the return address to store (IF_ID_pc + 1).
REQ-008 SHALL have port stack_out, output, WIDTH, the current top entry, feeding the RET path of the PC mux.
REQ-009 SHALL have port count, output, log2(DEPTH)+1, the number of valid entries.
REQ-010 SHALL have ports empty and full, output, 1 each: count==0 and count==DEPTH respectively.
REQ-011 SHALL have ports overflow and underflow, output, 1 each, sticky error flags.

Function
REQ-012 SHALL drive stack_out combinationally from the top entry (index count-1); stack_out SHALL be 0 when empty.
REQ-013 SHALL, on push only with not full, write stack_in at index count and increment count; the new top SHALL be visible on stack_out the cycle after the edge.
REQ-014 SHALL, on pop only with not empty, decrement count; the popped value SHALL be valid on stack_out during the pop cycle (zero-latency read).
REQ-015 SHALL, on push and pop together with not empty, overwrite the top entry with stack_in and leave count unchanged; overflow SHALL NOT be set, even when full.
REQ-016 SHALL, on push and pop together with empty, act as push only and set underflow.
REQ-017 SHALL, on pop only with empty, leave count and storage unchanged and set underflow.
REQ-018 SHALL handle push only with full as set out in Configuration, and SHALL set overflow in both builds.
REQ-019 SHALL keep overflow and underflow set until reset; no other event SHALL clear them.
REQ-020 SHALL compute count and pointers modulo-correctly, with no out-of-range index at count==0 or count==DEPTH.
REQ-021 SHALL keep all state unchanged when neither push nor pop is asserted.

Reset
REQ-022 SHALL, on a clk edge with reset==0, set count=0, empty=1, full=0, overflow=0, underflow=0 and stack_out=0; push and pop in that cycle SHALL be ignored.
REQ-023 SHALL let reset asserted mid-sequence (for example, during a push while full) take priority over every other operation.
REQ-024 SHALL NOT be required to clear storage contents on reset; they SHALL be unobservable until rewritten.

Configuration
REQ-025 SHALL, with macro RET_STACK_WRAP_EN defined, treat push on full as a circular push: the oldest entry is discarded, stack_in becomes the top, and count stays DEPTH.
REQ-026 SHALL, with RET_STACK_WRAP_EN undefined, ignore push on full: storage and count are unchanged and stack_out keeps the old top.

Verification
REQ-027 SHALL cover: reset low for 1 cycle, then push 12'h010, 12'h020, 12'h030 -> count=3 and stack_out=12'h030; 3 pops -> stack_out reads 030, 020, 010, then 000 with empty=1.
REQ-028 SHALL cover: from empty, pop -> underflow=1 and count=0; then push 12'h0AB -> underflow still 1, stack_out=12'h0AB.
REQ-029 SHALL cover: fill with 12'h001..12'h008, then push 12'h0FF -> overflow=1; WRAP_EN build: top=0FF, 8 pops read 0FF, 008..002; non-WRAP build: top=008, 8 pops read 008..001.
REQ-030 SHALL cover: count=2 with top=12'h020, push+pop of 12'h055 -> count=2, stack_out=12'h055, next entry down unchanged.
REQ-031 SHALL cover: count=8, push+pop of 12'h123 -> overflow=0, count=8, top=12'h123.
REQ-032 SHALL cover: count=5 and overflow=1, reset asserted together with push -> count=0, overflow=0, empty=1 on the next cycle.
